// File: rtl/obstacle_spawner_pkg.sv
// -----------------------------------------------------------------------------
// obstacle_spawner_pkg
// Shared game definitions: coordinate width, slot count, field geometry,
// scroll-speed tuning, shape codes, the parked-slot x value and the spawner
// state encoding. The collision stage uses the same COORD_W and packing.
// -----------------------------------------------------------------------------
package obstacle_spawner_pkg;

  localparam int COORD_W    = 11;
  localparam int NUM_SLOTS  = 5;
  localparam int SLOT_IDX_W = $clog2(NUM_SLOTS);

  localparam logic [COORD_W-1:0] SPAWN_X      = 11'd159;
  localparam logic [COORD_W-1:0] GROUND_Y     = 11'd89;
  localparam logic [COORD_W-1:0] BLOCK_SIZE   = 11'd10;
  localparam logic [COORD_W-1:0] RAISED_Y     = GROUND_Y - BLOCK_SIZE;
  localparam logic [COORD_W-1:0] MIN_GAP      = 11'd40;
  localparam logic [COORD_W-1:0] SPEED_INIT   = 11'd1;
  localparam logic [COORD_W-1:0] SPEED_MAX    = 11'd4;
  localparam logic [COORD_W-1:0] SPEEDUP_DIST = 11'd512;
  localparam logic [COORD_W-1:0] GAP_SAT      = 11'h7FF;
  localparam logic [COORD_W-1:0] PARK_X       = 11'h7FF;
  localparam logic [15:0]        LFSR_SEED    = 16'hACE1;

  localparam logic SHAPE_GROUND = 1'b0;
  localparam logic SHAPE_RAISED = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_RETIRE,
    ST_SPAWN
  } state_e;

  // True once an obstacle's right edge has scrolled past the left screen edge:
  // its screen-relative x (11-bit wrap, read as signed) is at or below -BLOCK_SIZE.
  function automatic logic is_offscreen(input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] scroll);
    logic [COORD_W-1:0] rel;
    rel = x - scroll;
    return $signed(rel) <= $signed(-BLOCK_SIZE);
  endfunction

endpackage

// File: rtl/obstacle_spawner_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1. Advances
// one position per cycle with step high; holds otherwise.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous, active-high; loads SEED
//   step   in   advance one position
//   value  out  current register contents
// -----------------------------------------------------------------------------
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;
  logic        feedback;

  always_comb begin
    feedback = value_q[15] ^ value_q[13] ^ value_q[12] ^ value_q[10];
    value_d  = value_q;
    if (step) begin
      value_d = {value_q[14:0], feedback};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/obstacle_spawner.sv
// -----------------------------------------------------------------------------
// obstacle_spawner
// Scrolls and maintains the obstacle field: five world-coordinate slots,
// pseudo-random spawn spacing and height, retirement of slots that have left
// the screen, and a scroll speed that rises with distance travelled.
// Ports:
//   clock          in   system clock
//   reset          in   synchronous, active-high
//   enable         in   game running; low freezes the field
//   update_screen  in   one-cycle frame pulse
//   block_x_pos    out  slot i world x in bits [11i+10:11i] (PARK_X when empty)
//   block_y_pos    out  slot i bottom-left y, same packing (0 when empty)
//   block_valid    out  slot occupancy
//   curr_shape_id  out  shape code of the last spawn, zero-extended
//   move_counter   out  scroll step applied on each frame; 0 while idle
// -----------------------------------------------------------------------------
module obstacle_spawner
  import obstacle_spawner_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           update_screen,
  output logic [NUM_SLOTS*COORD_W-1:0]   block_x_pos,
  output logic [NUM_SLOTS*COORD_W-1:0]   block_y_pos,
  output logic [NUM_SLOTS-1:0]           block_valid,
  output logic [COORD_W-1:0]             curr_shape_id,
  output logic [COORD_W-1:0]             move_counter
);

  state_e                              state_q, state_d;
  logic [COORD_W-1:0]                  scroll_q, scroll_d;
  logic [COORD_W-1:0]                  dist_q, dist_d;
  logic [COORD_W-1:0]                  speed_q, speed_d;
  logic [COORD_W-1:0]                  gap_cnt_q, gap_cnt_d;
  logic [COORD_W-1:0]                  gap_target_q, gap_target_d;
  logic [COORD_W-1:0]                  move_counter_q, move_counter_d;
  logic                                pending_q, pending_d;
  logic                                shape_q, shape_d;
  logic [NUM_SLOTS-1:0]                valid_q, valid_d;
  logic [NUM_SLOTS-1:0][COORD_W-1:0]   x_q, x_d;
  logic [NUM_SLOTS-1:0][COORD_W-1:0]   y_q, y_d;

  logic [15:0]                         lfsr_value;
  logic                                lfsr_step;
  logic                                unused_lfsr_bits;
  logic [COORD_W:0]                    gap_sum;
  logic                                free_found;
  logic [SLOT_IDX_W-1:0]               free_idx;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  // Only bits [5:0] steer spawning; the rest just carry the sequence.
  assign unused_lfsr_bits = ^lfsr_value[15:6];

  // Lowest-index free slot; scanning downward lets the last hit win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_IDX_W'(i);
      end
    end
  end

  assign gap_sum = {1'b0, gap_cnt_q} + {1'b0, speed_q};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d      = state_q;
    scroll_d     = scroll_q;
    dist_d       = dist_q;
    speed_d      = speed_q;
    gap_cnt_d    = gap_cnt_q;
    gap_target_d = gap_target_q;
    pending_d    = pending_q;
    shape_d      = shape_q;
    valid_d      = valid_q;
    x_d          = x_q;
    y_d          = y_q;
    lfsr_step    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (update_screen || pending_q) begin
          // The step applied here is the move_counter value on the port now.
          scroll_d  = scroll_q + speed_q;
          dist_d    = dist_q + speed_q;
          gap_cnt_d = gap_sum[COORD_W] ? GAP_SAT : gap_sum[COORD_W-1:0];
          pending_d = 1'b0;
          state_d   = ST_RETIRE;
        end
      end

      ST_RETIRE: begin
        if (update_screen) begin
          pending_d = 1'b1;
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (valid_q[i] && is_offscreen(x_q[i], scroll_q)) begin
            valid_d[i] = 1'b0;
            x_d[i]     = PARK_X;
            y_d[i]     = '0;
          end
        end
        // Speed moves one edge after the frame that crossed the threshold, so
        // downstream never sees a step different from the one applied.
        if (dist_q >= SPEEDUP_DIST) begin
          dist_d = dist_q - SPEEDUP_DIST;
          if (speed_q < SPEED_MAX) begin
            speed_d = speed_q + 11'd1;
          end
        end
        state_d = ST_SPAWN;
      end

      ST_SPAWN: begin
        if (update_screen) begin
          pending_d = 1'b1;
        end
        // valid_q already reflects this frame's retirements.
        if (gap_cnt_q >= gap_target_q && free_found) begin
          valid_d[free_idx] = 1'b1;
          x_d[free_idx]     = scroll_q + SPAWN_X;
          y_d[free_idx]     = lfsr_value[0] ? RAISED_Y : GROUND_Y;
          shape_d           = lfsr_value[0] ? SHAPE_RAISED : SHAPE_GROUND;
          gap_cnt_d         = '0;
          gap_target_d      = MIN_GAP + COORD_W'(lfsr_value[5:1]);
          lfsr_step         = 1'b1;
        end
        state_d = ST_RUN;
      end

      default: state_d = ST_IDLE;
    endcase

    move_counter_d = (state_d == ST_IDLE) ? '0 : speed_d;
  end

  always_ff @(posedge clock) begin
    // NOTE: the slot registers are reset along with the control state because
    // their values drive the outputs directly and must park on reset.
    if (reset) begin
      state_q        <= ST_IDLE;
      scroll_q       <= '0;
      dist_q         <= '0;
      speed_q        <= SPEED_INIT;
      gap_cnt_q      <= GAP_SAT;
      gap_target_q   <= MIN_GAP;
      pending_q      <= 1'b0;
      shape_q        <= SHAPE_GROUND;
      move_counter_q <= '0;
      valid_q        <= '0;
      x_q            <= {NUM_SLOTS{PARK_X}};
      y_q            <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples
      // the values from before this edge.
      state_q        <= state_d;
      scroll_q       <= scroll_d;
      dist_q         <= dist_d;
      speed_q        <= speed_d;
      gap_cnt_q      <= gap_cnt_d;
      gap_target_q   <= gap_target_d;
      pending_q      <= pending_d;
      shape_q        <= shape_d;
      move_counter_q <= move_counter_d;
      valid_q        <= valid_d;
      x_q            <= x_d;
      y_q            <= y_d;
    end
  end

  assign block_x_pos   = x_q;
  assign block_y_pos   = y_q;
  assign block_valid   = valid_q;
  assign curr_shape_id = {{(COORD_W-1){1'b0}}, shape_q};
  assign move_counter  = move_counter_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// -----------------------------------------------------------------------------
// tb_obstacle_spawner
// Randomized frame timing and enable pauses against a frame-level reference
// model of the obstacle field (scroll, gap, retire, spawn, speed-up).
// -----------------------------------------------------------------------------
module tb_obstacle_spawner;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        update_screen;
  logic [54:0] block_x_pos;
  logic [54:0] block_y_pos;
  logic [4:0]  block_valid;
  logic [10:0] curr_shape_id;
  logic [10:0] move_counter;

  obstacle_spawner dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .update_screen (update_screen),
    .block_x_pos   (block_x_pos),
    .block_y_pos   (block_y_pos),
    .block_valid   (block_valid),
    .curr_shape_id (curr_shape_id),
    .move_counter  (move_counter)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state, plain integers.
  int          m_scroll, m_dist, m_speed, m_gap, m_target, m_shape;
  int          m_x[5];
  int          m_y[5];
  bit          m_valid[5];
  logic [15:0] m_lfsr;
  int          m_spawns;
  int          m_second_frame;
  int          frame_no;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  task automatic model_reset();
    m_scroll = 0; m_dist = 0; m_speed = 1; m_gap = 2047; m_target = 40;
    m_shape = 0; m_lfsr = 16'hACE1; m_spawns = 0; m_second_frame = 0;
    for (int i = 0; i < 5; i++) begin
      m_x[i] = 2047; m_y[i] = 0; m_valid[i] = 1'b0;
    end
  endtask

  // Frame first half: scroll forward, drop off-screen slots, speed up.
  task automatic model_move_retire();
    int rel;
    m_scroll = (m_scroll + m_speed) % 2048;
    m_dist   = m_dist + m_speed;
    m_gap    = (m_gap + m_speed > 2047) ? 2047 : m_gap + m_speed;
    for (int i = 0; i < 5; i++) begin
      if (m_valid[i]) begin
        rel = ((m_x[i] - m_scroll) % 2048 + 2048) % 2048;
        if (rel >= 1024) rel = rel - 2048;
        if (rel <= -10) begin
          m_valid[i] = 1'b0; m_x[i] = 2047; m_y[i] = 0;
        end
      end
    end
    if (m_dist >= 512) begin
      m_dist = m_dist - 512;
      if (m_speed < 4) m_speed++;
    end
  endtask

  // Frame second half: place a new obstacle if the gap allows and a slot is free.
  task automatic model_spawn();
    int slot;
    slot = -1;
    for (int i = 4; i >= 0; i--) if (!m_valid[i]) slot = i;
    if (m_gap >= m_target && slot >= 0) begin
      m_valid[slot] = 1'b1;
      m_x[slot]     = (m_scroll + 159) % 2048;
      m_y[slot]     = m_lfsr[0] ? 79 : 89;
      m_shape       = int'(m_lfsr[0]);
      m_gap         = 0;
      m_target      = 40 + int'((m_lfsr >> 1) & 16'h1F);
      m_lfsr        = lfsr_next(m_lfsr);
      m_spawns++;
      if (m_spawns == 2) m_second_frame = frame_no;
    end
  endtask

  function automatic logic [4:0] model_valid();
    logic [4:0] v;
    for (int i = 0; i < 5; i++) v[i] = m_valid[i];
    return v;
  endfunction

  task automatic compare_all(input string tag, input int exp_mc);
    logic [54:0] ex, ey;
    for (int i = 0; i < 5; i++) begin
      ex[i*11 +: 11] = 11'(m_x[i]);
      ey[i*11 +: 11] = 11'(m_y[i]);
    end
    check({tag, "_valid"}, 64'(block_valid), 64'(model_valid()));
    check({tag, "_x"}, 64'(block_x_pos), 64'(ex));
    check({tag, "_y"}, 64'(block_y_pos), 64'(ey));
    check({tag, "_shape"}, 64'(curr_shape_id), 64'(m_shape));
    check({tag, "_move"}, 64'(move_counter), 64'(exp_mc));
  endtask

  // One frame from RUN, back in RUN afterwards. With drop_mid the enable falls
  // while the frame is in flight; the frame must still finish before idling.
  task automatic do_frame(input bit drop_mid);
    logic [4:0] pre_valid;
    frame_no++;
    check("move_at_pulse", 64'(move_counter), 64'(m_speed));
    if (frame_no == 512) check("move_f512", 64'(move_counter), 64'd1);
    if (frame_no == 513) check("move_f513", 64'(move_counter), 64'd2);
    pre_valid = model_valid();
    update_screen = 1'b1;
    tick();
    update_screen = 1'b0;
    if (drop_mid) enable = 1'b0;
    check("valid_at_t", 64'(block_valid), 64'(pre_valid));
    if (frame_no == 170) check("slot0_live_at_t", 64'(block_valid[0]), 64'd1);
    model_move_retire();
    tick();
    check("valid_at_t1", 64'(block_valid), 64'(model_valid()));
    if (frame_no == 170) check("slot0_retired_t1", 64'(block_valid[0]), 64'd0);
    model_spawn();
    tick();
    compare_all("frame", m_speed);
    if (drop_mid) begin
      tick();
      check("idle_after_drop", 64'(move_counter), 64'd0);
      enable = 1'b1;
      tick();
      check("run_after_drop", 64'(move_counter), 64'(m_speed));
    end
  endtask

  task automatic idle_pause();
    enable = 1'b0;
    tick();
    check("idle_move", 64'(move_counter), 64'd0);
    update_screen = 1'b1;
    tick();
    update_screen = 1'b0;
    check("idle_ignores_frame", 64'(move_counter), 64'd0);
    enable = 1'b1;
    tick();
    check("resume_move", 64'(move_counter), 64'(m_speed));
  endtask

  initial begin
    int dut_second;
    bit seen_second;
    reset = 1'b1; enable = 1'b0; update_screen = 1'b0;
    frame_no = 0; dut_second = 0; seen_second = 1'b0;
    model_reset();
    tick(); tick();
    compare_all("reset", 0);

    reset = 1'b0; enable = 1'b1;
    tick();
    check("enter_run_move", 64'(move_counter), 64'd1);

    // First frame: spawn at 1 + 159, raised because lfsr[0] of the seed is 1.
    do_frame(1'b0);
    check("first_valid", 64'(block_valid), 64'h01);
    check("first_x", 64'(block_x_pos[10:0]), 64'd160);
    check("first_y", 64'(block_y_pos[10:0]), 64'd79);
    check("first_move", 64'(move_counter), 64'd1);

    for (int f = 2; f <= 1100; f++) begin
      repeat ($urandom_range(2)) tick();
      if ($urandom_range(39) == 0) idle_pause();
      do_frame(f == 300);
      if (!seen_second && $countones(block_valid) >= 2) begin
        seen_second = 1'b1;
        dut_second  = frame_no;
      end
    end
    check("second_spawn_frame", 64'(dut_second), 64'(m_second_frame));
    check("second_spawn_not_early", 64'(dut_second >= 41), 64'd1);
    check("speed_saturated", 64'(move_counter), 64'd4);

    // Pulses held through RETIRE and SPAWN: exactly one extra frame is queued.
    update_screen = 1'b1;
    tick(); tick(); tick();
    update_screen = 1'b0;
    tick(); tick(); tick();
    frame_no++; model_move_retire(); model_spawn();
    frame_no++; model_move_retire(); model_spawn();
    compare_all("pending", m_speed);

    // Reset asserted while in SPAWN.
    update_screen = 1'b1;
    tick();
    update_screen = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    model_reset();
    compare_all("reset_in_spawn", 0);
    reset = 1'b0;
    tick();
    frame_no = 0;
    do_frame(1'b0);
    check("restart_x", 64'(block_x_pos[10:0]), 64'd160);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
